// File: rtl/trng_pkg.sv
// trng_pkg: shared state type and default sizing for the TRNG conditioner.
// No ports. It provides the conditioner state enum and the default word width
// and repetition limit.
package trng_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, FAIL} trng_cond_state_t;
   localparam int TRNG_WORD_WIDTH = 32;
   localparam int TRNG_REP_LIMIT = 31;
endpackage

// File: rtl/trng_conditioner_if.sv
// trng_conditioner_if: valid/ready word output bus of the TRNG conditioner.
// Signals: data_out (head word), data_valid (word available), data_ready
// (consumer accepts), fifo_level (occupied entries).
// Modports: master is the conditioner side, slave is the consumer side.
interface trng_conditioner_if #(
   parameter int WORD_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
);
   logic [WORD_WIDTH-1:0] data_out;
   logic data_valid;
   logic data_ready;
   logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level;
   modport master (output data_out, data_valid, fifo_level, input data_ready);
   modport slave (input data_out, data_valid, fifo_level, output data_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count.
// Ports: clk, reset (async, active-high), push/din (write), pop (read
// acknowledge), dout (head word, 0 when empty), full, empty, level.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic full,
   output logic empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = level == '0;
   assign full = level == LW'(DEPTH);
   assign do_pop = pop && !empty;
   // a full FIFO still accepts a word when the head leaves on the same edge
   assign do_push = push && (!full || do_pop);
   assign dout = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(do_push) - LW'(do_pop);
      end
endmodule

// File: rtl/trng_conditioner.sv
// trng_conditioner: von Neumann debiasing, repetition-count health test and
// word packing of a raw TRNG bit stream, buffered in a FIFO.
// Ports: clk, reset (async, active-high), enable (collection enable),
// trng_in (raw bit), health_fail (sticky), overflow (sticky),
// bus (word output: data_out, data_valid, data_ready, fifo_level).
module trng_conditioner
   import trng_pkg::*;
#(
   parameter int WORD_WIDTH = TRNG_WORD_WIDTH,
   parameter int REP_LIMIT = TRNG_REP_LIMIT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic trng_in,
   output logic health_fail,
   output logic overflow,
   trng_conditioner_if.master bus
);
   localparam int BW = $clog2(WORD_WIDTH);
   localparam int RW = $clog2(REP_LIMIT+1);
   trng_cond_state_t state, state_nxt;
   logic pair_bit, pair_full, prev_bit;
   logic [WORD_WIDTH-1:0] word;
   logic [BW-1:0] bit_cnt;
   logic [RW-1:0] run_cnt, run_nxt;
   logic rep_hit, emit, word_done, push, pop, full, empty;
   assign pop = bus.data_valid && bus.data_ready;
   assign bus.data_valid = !empty;
   always_comb begin
      // run_cnt of 0 marks the first sample of a collection
      run_nxt = (run_cnt == '0 || trng_in != prev_bit) ? RW'(1) : run_cnt + 1'b1;
      rep_hit = run_nxt == RW'(REP_LIMIT);
      emit = pair_full && pair_bit != trng_in;
      word_done = emit && bit_cnt == BW'(WORD_WIDTH-1);
      state_nxt = state;
      push = 1'b0;
      case (state)
         IDLE: state_nxt = enable ? COLLECT : IDLE;
         COLLECT: begin
            state_nxt = !enable ? IDLE : rep_hit ? FAIL : COLLECT;
            push = enable && !rep_hit && word_done;
         end
         default: state_nxt = enable ? FAIL : IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pair_bit <= 1'b0;
         pair_full <= 1'b0;
         prev_bit <= 1'b0;
         word <= '0;
         bit_cnt <= '0;
         run_cnt <= '0;
         health_fail <= 1'b0;
         overflow <= 1'b0;
      end else begin
         // leaving or outside COLLECT discards the pair and the partial word
         if (state != COLLECT || state_nxt != COLLECT) begin
            pair_bit <= 1'b0;
            pair_full <= 1'b0;
            prev_bit <= 1'b0;
            word <= '0;
            bit_cnt <= '0;
            run_cnt <= '0;
         end else begin
            prev_bit <= trng_in;
            run_cnt <= run_nxt;
            pair_full <= !pair_full;
            if (!pair_full) pair_bit <= trng_in;
            if (emit) begin
               word <= {word[WORD_WIDTH-2:0], pair_bit};
               bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
         end
         if (state == IDLE && enable) begin
            health_fail <= 1'b0;
            overflow <= 1'b0;
         end else begin
            if (state_nxt == FAIL) health_fail <= 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
         end
      end
   sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .din({word[WORD_WIDTH-2:0], pair_bit}),
      .dout(bus.data_out),
      .full(full),
      .empty(empty),
      .level(bus.fifo_level)
   );
endmodule

// File: tb/tb_trng_conditioner.sv
// tb_trng_conditioner: randomized scoreboard bench for trng_conditioner.
// A reference model tracks raw samples of each collection as a queue and
// derives emitted bits, words, FIFO occupancy and the sticky flags from them.
module tb_trng_conditioner;
   localparam int W = 32, REP = 31, DEPTH = 4;
   logic clk = 0, reset = 0, enable = 0, trng_in = 0;
   logic health_fail, overflow;
   trng_conditioner_if #(.WORD_WIDTH(W), .FIFO_DEPTH(DEPTH)) bus ();
   trng_conditioner #(.WORD_WIDTH(W), .REP_LIMIT(REP), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .trng_in(trng_in),
      .health_fail(health_fail),
      .overflow(overflow),
      .bus(bus)
   );
   always #5 clk = ~clk;
   int errors = 0, checks = 0;
   bit m_on, m_fail, m_hf, m_ov;
   bit raw[$];
   bit bits[$];
   logic [W-1:0] exp_q[$];
   int m_level = 0, m_words = 0, popped = 0;
   logic [W-1:0] last_word = '0;
   function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endfunction
   task automatic model_edge(bit en, bit b, bit rdy);
      bit pop, push;
      logic [W-1:0] w;
      int run;
      pop = m_level > 0 && rdy;
      push = 0;
      w = '0;
      if (!m_on && !m_fail) begin
         if (en) begin
            m_on = 1; m_hf = 0; m_ov = 0;
            raw.delete(); bits.delete();
         end
      end else if (m_fail) begin
         if (!en) m_fail = 0;
      end else if (!en) m_on = 0;
      else begin
         raw.push_back(b);
         run = 0;
         for (int i = raw.size() - 1; i >= 0 && raw[i] == b; i--) run++;
         if (run >= REP) begin
            m_on = 0; m_fail = 1; m_hf = 1;
         end else if (raw.size() % 2 == 0 && raw[raw.size()-2] != b) begin
            bits.push_back(raw[raw.size()-2]);
            if (bits.size() == W) begin
               foreach (bits[i]) w[W-1-i] = bits[i];
               push = 1;
               m_words++;
               bits.delete();
            end
         end
      end
      if (push) begin
         if (m_level < DEPTH || pop) begin
            exp_q.push_back(w);
            m_level++;
         end else m_ov = 1;
      end
      if (pop) m_level--;
   endtask
   task automatic step(bit en, bit b, bit rdy);
      enable = en; trng_in = b; bus.data_ready = rdy;
      @(posedge clk);
      model_edge(en, b, rdy);
      #1;
   endtask
   task automatic check_zero(string tag);
      check({tag, "_data"}, bus.data_out, 0);
      check({tag, "_valid"}, bus.data_valid, 0);
      check({tag, "_level"}, bus.fifo_level, 0);
      check({tag, "_hf"}, health_fail, 0);
      check({tag, "_ov"}, overflow, 0);
   endtask
   task automatic do_reset();
      reset = 1; enable = 0; bus.data_ready = 0;
      m_on = 0; m_fail = 0; m_hf = 0; m_ov = 0; m_level = 0;
      raw.delete(); bits.delete(); exp_q.delete();
      #1;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
   endtask
   always @(negedge clk) begin
      check("level", bus.fifo_level, m_level);
      check("valid", bus.data_valid, m_level > 0);
      check("health_fail", health_fail, m_hf);
      check("overflow", overflow, m_ov);
      if (bus.data_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word got=%h exp=none", bus.data_out);
         end else begin
            check("data", bus.data_out, exp_q[0]);
            if (bus.data_ready) begin
               last_word = bus.data_out;
               void'(exp_q.pop_front());
               popped++;
            end
         end
      end
   end
   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      int p0, start;
      logic [W-1:0] w;
      bit b, en_r, pb;
      int hold;
      bus.data_ready = 0;
      #2;
      do_reset();
      // word assembly
      p0 = popped;
      step(1, 0, 1);
      repeat (16) begin step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 1, 1); end
      repeat (3) step(0, 0, 1);
      check("wa_count", popped - p0, 1);
      check("wa_word", last_word, 32'hAAAAAAAA);
      // discarded pairs interleaved
      p0 = popped;
      step(1, 0, 1);
      repeat (16) begin
         step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
         step(1, 0, 1); step(1, 1, 1); step(1, 1, 1); step(1, 1, 1);
      end
      repeat (3) step(0, 0, 1);
      check("dp_count", popped - p0, 1);
      check("dp_word", last_word, 32'hAAAAAAAA);
      // health failure
      step(1, 0, 1);
      repeat (REP) step(1, 1, 1);
      check("hf_set", health_fail, 1);
      check("hf_nopush", bus.fifo_level, 0);
      repeat (10) step(1, bit'($urandom_range(0, 1)), 1);
      check("hf_sticky", health_fail, 1);
      check("hf_nopush2", bus.fifo_level, 0);
      step(0, 0, 1);
      check("hf_idle", health_fail, 1);
      step(1, 0, 1);
      check("hf_clear", health_fail, 0);
      // overflow with consumer stalled
      start = m_words;
      for (int n = 0; n < 5000 && m_words < start + 5; n++) step(1, bit'($urandom_range(0, 1)), 0);
      check("ov_words", m_words - start, 5);
      check("ov_level", bus.fifo_level, 4);
      check("ov_flag", overflow, 1);
      p0 = popped;
      repeat (8) step(0, 0, 1);
      check("ov_drain", popped - p0, 4);
      // push and pop on the same edge at full
      step(1, 0, 0);
      start = m_words;
      for (int n = 0; n < 5000 && m_words < start + 4; n++) step(1, bit'($urandom_range(0, 1)), 0);
      for (int n = 0; n < 2000; n++) begin
         if (bits.size() == W - 1 && raw.size() % 2 == 1) begin
            step(1, !raw[raw.size()-1], 1);
            break;
         end
         step(1, bit'($urandom_range(0, 1)), 0);
      end
      check("pp_words", m_words - start, 5);
      check("pp_level", bus.fifo_level, 4);
      check("pp_ov", overflow, 0);
      repeat (6) step(0, 0, 1);
      // aborted collection
      p0 = popped;
      step(1, 0, 1);
      repeat (20) begin step(1, 1, 1); step(1, 0, 1); end
      step(0, 0, 1);
      repeat (2) step(0, 0, 1);
      check("ab_level", bus.fifo_level, 0);
      check("ab_nopush", popped - p0, 0);
      step(1, 0, 1);
      w = $urandom;
      for (int i = 0; i < W; i++) begin
         b = w[W-1-i];
         step(1, b, 1);
         step(1, !b, 1);
      end
      repeat (3) step(0, 0, 1);
      check("ab_count", popped - p0, 1);
      check("ab_word", last_word, w);
      // reset mid-word with a word buffered
      step(1, 0, 0);
      start = m_words;
      for (int n = 0; n < 2000 && m_words < start + 1; n++) step(1, bit'($urandom_range(0, 1)), 0);
      repeat (10) step(1, bit'($urandom_range(0, 1)), 0);
      check("rst_pre", bus.fifo_level, 1);
      do_reset();
      // randomized soak
      en_r = 1; pb = 0; hold = 0;
      repeat (3000) begin
         if ($urandom_range(0, 299) == 0) en_r = !en_r;
         if (hold == 0 && $urandom_range(0, 599) == 0) hold = 40;
         if (hold > 0) hold--;
         else if ($urandom_range(0, 9) >= 7) pb = !pb;
         step(en_r, pb, $urandom_range(0, 3) != 0);
      end
      repeat (10) step(0, 0, 1);
      check("soak_empty", bus.fifo_level, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
